vram_arbiter: RTL
=================

# vram_arbiter

Arbitrates one single-port synchronous video RAM between the video scan-out (read-only, fixed latency, absolute priority) and the CPU bus (read/write, request/ready handshake). It sits inside `SpaceInvaders` on the `CLK_25MHZ` domain, between the framebuffer RAM and its two users. An optional detector flags CPU starvation during long video bursts.

## Interface
- `ADDR_W`, default 13: VRAM address width, in words.
- `DATA_W`, default 8: VRAM data width.
- `MAX_WAIT`, default 64: number of consecutive CPU wait cycles that counts as starvation. Legal range is 1..255.

Ports:
- `CLK_25MHZ`  in  1: single clock. Everything is rising-edge.
- `RESET`  in  1: synchronous, active-high reset.
- `vid_req`  in  1: video read request, one word per cycle.
- `vid_addr`  in  ADDR_W: video read address.
- `vid_valid`  out  1: `vid_data` is valid.
- `vid_data`  out  DATA_W: video read data.
- `cpu_req`  in  1: CPU access request. The CPU holds it until `cpu_ready`.
- `cpu_we`  in  1: 1 for a write, 0 for a read.
- `cpu_addr`  in  ADDR_W: CPU address.
- `cpu_wdata`  in  DATA_W: CPU write data.
- `cpu_ready`  out  1: single-cycle completion pulse.
- `cpu_rdata`  out  DATA_W: CPU read data, valid only while `cpu_ready`=1.
- `ram_en`, `ram_we`  out  1 each: RAM enable and write enable.
- `ram_addr`  out  ADDR_W: RAM address.
- `ram_wdata`  out  DATA_W: RAM write data.
- `ram_rdata`  in  DATA_W: RAM read data, one cycle after `ram_en`.
- `cpu_starved`  out  1: sticky starvation flag.

## Operation
- Per-cycle grant decision, combinational from the current inputs and state:
  - `RESET`=1: no grant. `ram_en`=0, `ram_we`=0.
  - `vid_req`=1: video granted. `ram_en`=1, `ram_we`=0, `ram_addr`=`vid_addr`.
  - Otherwise, state=`IDLE` and `cpu_req`=1: CPU granted. `ram_en`=1, `ram_we`=`cpu_we`, `ram_addr`=`cpu_addr`, `ram_wdata`=`cpu_wdata`.
  - Otherwise: `ram_en`=0, `ram_we`=0.
- FSM states are `IDLE` and `DONE`.
  - `IDLE` to `DONE` on a CPU grant.
  - `DONE` to `IDLE` unconditionally after one cycle.
  - `cpu_req` is ignored while in `DONE`. This prevents re-issuing a request the CPU is still holding.
- `cpu_ready` = (state == `DONE`). It is asserted for reads and writes alike.
- `cpu_rdata` and `vid_data` are wired directly to `ram_rdata`.
- `vid_valid` is `vid_req & ~RESET`, delayed one cycle.
- CPU protocol:
  - `cpu_we`, `cpu_addr` and `cpu_wdata` stay stable from `cpu_req` rise until `cpu_ready`.
  - The CPU may drop `cpu_req` or present a new request in the cycle after `cpu_ready`.
- Wait counter: 8-bit, saturating at `MAX_WAIT`.
  - Increments each cycle that `cpu_req`=1, state=`IDLE` and video is granted.
  - Clears on any CPU grant.
- A video read and a CPU write to the same address in the same cycle: video wins and reads the old data. The CPU write is issued later.
- Reset mid-operation drops any pending or issued CPU access. No `cpu_ready` is produced for it. A write already in `DONE` has been committed to RAM.

## Timing
- Reset values:
  - registered outputs: `vid_valid`=0, `cpu_ready`=0, `cpu_starved`=0;
  - internal state: FSM=`IDLE`, wait counter=0;
  - during reset: `ram_en`=0, `ram_we`=0.
- Video latency: request in cycle t, `vid_valid` and `vid_data` in t+1. The rate is one word per cycle, fully pipelined and never stalled.
- CPU latency: granted in cycle t, `cpu_ready` in t+1.
  - Minimum CPU access period is 2 cycles.
  - The grant is delayed while `vid_req` is high; the delay is unbounded.
- Back-to-back operation:
  - `vid_req` may rise in the `DONE` cycle; video is granted and the CPU completes normally.
  - A CPU request can be granted in t+1 only if the state is `IDLE` there, which is never true immediately after a grant.

## Configuration
- `VRAM_ARB_STARVE_DET_EN` defined:
  - the wait counter is built;
  - `cpu_starved` is set in the cycle after the counter reaches `MAX_WAIT`;
  - it stays set until `RESET`.
- Not defined: the counter is removed and `cpu_starved` is tied to 0. Grant behaviour is identical.

## Test plan
- Reset, then idle for 10 cycles: `vid_valid`=`cpu_ready`=`ram_en`=0 throughout.
- CPU write 0xA5 to 0x0123 with no video: `ram_we`=1 in t, `cpu_ready` pulses once in t+1. A following CPU read of 0x0123 returns `cpu_rdata`=0xA5 with `cpu_ready`.
- `vid_req` high for 20 cycles over addresses 0..19 while `cpu_req` is held:
  - 20 `vid_valid` pulses with data matching RAM contents;
  - the CPU grant occurs in the first cycle `vid_req`=0;
  - `cpu_ready` follows 1 cycle later.
- Same-address collision, video read and CPU write of 0x3C to 0x0040 in the same cycle:
  - the video sees the old value;
  - the write lands afterwards;
  - a later video read returns 0x3C.
- `RESET` asserted in the `DONE` cycle: no `cpu_ready`. After release the FSM is `IDLE`, and a held `cpu_req` is re-granted in the first cycle.
- With `VRAM_ARB_STARVE_DET_EN` and `MAX_WAIT`=4, `cpu_req` held during 4 video cycles: `cpu_starved`=1 from the next cycle and stays 1 after a CPU grant. Without the macro it stays 0.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bus bundle between the VRAM arbiter, its video and CPU users and the RAM.
interface vram_arbiter_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_valid;
    logic [DATA_W-1:0] vid_data;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              cpu_starved;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_valid, vid_data, cpu_ready, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata,
               cpu_starved
    );
    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_valid, vid_data, cpu_ready, cpu_rdata, ram_en, ram_we, ram_addr, ram_wdata,
               cpu_starved
    );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM arbiter, video reads have absolute priority over a CPU req/ready port.
// Define VRAM_ARB_STARVE_DET_EN to build the CPU starvation detector (cpu_starved).
module vram_arbiter #(
    parameter int MAX_WAIT = 64
) (
    input logic           CLK_25MHZ,
    input logic           RESET,
    vram_arbiter_if.slave bus
);
    typedef enum logic {IDLE, DONE} state_t;
    state_t r_state, w_state_nxt;
    logic   r_vid_valid;
    logic   w_vid_gnt, w_cpu_gnt;

    always_comb begin
        w_vid_gnt     = ~RESET & bus.vid_req;
        w_cpu_gnt     = ~RESET & ~bus.vid_req & bus.cpu_req & (r_state == IDLE);
        w_state_nxt   = w_cpu_gnt ? DONE : IDLE;
        bus.ram_en    = w_vid_gnt | w_cpu_gnt;
        bus.ram_we    = w_cpu_gnt & bus.cpu_we;
        bus.ram_addr  = w_vid_gnt ? bus.vid_addr : bus.cpu_addr;
        bus.ram_wdata = bus.cpu_wdata;
    end

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            r_state     <= IDLE;
            r_vid_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_vid_valid <= bus.vid_req;
        end
    end

    // A reset landing in the completion cycle cancels the access, so ready is masked too
    assign bus.cpu_ready = (r_state == DONE) & ~RESET;
    assign bus.vid_valid = r_vid_valid;
    assign bus.vid_data  = bus.ram_rdata;
    assign bus.cpu_rdata = bus.ram_rdata;

`ifdef VRAM_ARB_STARVE_DET_EN
    logic [7:0] r_wait, w_wait_nxt;
    logic       r_starved;

    always_comb begin
        w_wait_nxt = w_cpu_gnt ? 8'd0 :
                     (w_vid_gnt & bus.cpu_req & (r_state == IDLE) & (r_wait < 8'(MAX_WAIT))) ?
                     r_wait + 8'd1 : r_wait;
    end

    always_ff @(posedge CLK_25MHZ) begin
        if (RESET) begin
            r_wait    <= 8'd0;
            r_starved <= 1'b0;
        end else begin
            r_wait    <= w_wait_nxt;
            r_starved <= r_starved | (w_wait_nxt == 8'(MAX_WAIT));
        end
    end

    assign bus.cpu_starved = r_starved;
`else
    assign bus.cpu_starved = 1'b0;
`endif
endmodule
